// File: rtl/pid_math_pkg.sv
// Shared types and the micro-program table for the PID math sequencer.
package pid_math_pkg;

   // ALU src0 mux encodings
   typedef enum logic [2:0] {
      S0_A2D    = 3'd0,
      S0_INTGRL = 3'd1,
      S0_ICOMP  = 3'd2,
      S0_PCOMP  = 3'd3,
      S0_PTERM  = 3'd4
   } src0_t;

   // ALU src1 mux encodings
   typedef enum logic [2:0] {
      S1_ACCUM     = 3'd0,
      S1_ITERM     = 3'd1,
      S1_ERROR     = 3'd2,
      S1_ERR_DIV16 = 3'd3,
      S1_FWD       = 3'd4
   } src1_t;

   // Sequencer states, one per micro-program step
   typedef enum logic [3:0] {
      IDLE, INTG, ICMP, PCMP, ACC1, RHT, ACC2, LFT, DONE
   } step_t;

   typedef struct packed {
      src0_t src0;
      src1_t src1;
      logic  multiply;
      logic  sub;
      logic  mult2;
      logic  mult4;
      logic  saturate;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_OFF = '{S0_A2D, S1_ACCUM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   // Control word driven while in each state, indexed by step_t
   localparam ctrl_word_t STEP_CTRL [9] = '{
      CTRL_OFF,                                                       // IDLE
      '{S0_INTGRL, S1_ERR_DIV16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},       // INTG
      '{S0_INTGRL, S1_ITERM,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0},       // ICMP
      '{S0_PTERM,  S1_ERROR,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0},       // PCMP
      '{S0_PCOMP,  S1_FWD,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0},       // ACC1
      '{S0_ICOMP,  S1_ACCUM,     1'b0, 1'b1, 1'b0, 1'b0, 1'b1},       // RHT
      '{S0_PCOMP,  S1_FWD,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0},       // ACC2
      '{S0_ICOMP,  S1_ACCUM,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1},       // LFT
      CTRL_OFF                                                        // DONE
   };

   localparam logic [11:0] SAT_POS = 12'h7FF;
   localparam logic [11:0] SAT_NEG = 12'h800;

   function automatic logic is_sat(input logic [11:0] v);
      return (v == SAT_POS) || (v == SAT_NEG);
   endfunction

endpackage

// File: rtl/pid_math_seq.sv
// PID math sequencer: steps the shared ALU through the PID micro-program on
// each go pulse and captures the ALU result into the source/motor registers.
// Optional build macro ANTI_WINDUP_EN: freezes the integrator for one pass
// after a pass whose motor outputs ended saturated.
module pid_math_seq
   import pid_math_pkg::*;
#(
   parameter int MUL_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic [15:0] dst,
   output logic [2:0]  src0sel,
   output logic [2:0]  src1sel,
   output logic        multiply,
   output logic        sub,
   output logic        mult2,
   output logic        mult4,
   output logic        saturate,
   output logic [15:0] accum,
   output logic [15:0] pcomp,
   output logic [11:0] icomp,
   output logic [11:0] intgrl,
   output logic [11:0] lft,
   output logic [11:0] rht,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] CNT_LAST = 2'(MUL_CYC - 1);

   step_t      state, nxt;
   logic [1:0] cnt;
   logic       step_end;
   ctrl_word_t ctrl_q;

`ifdef ANTI_WINDUP_EN
   logic       sat_flag;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next state; multiply steps only advance on their last count
   always_comb begin
      nxt      = state;
      step_end = 1'b1;
      if (state == ICMP || state == PCMP) step_end = (cnt == CNT_LAST);
      case (state)
         IDLE:    if (go) nxt = INTG;
         INTG:    nxt = ICMP;
         ICMP:    if (step_end) nxt = PCMP;
         PCMP:    if (step_end) nxt = ACC1;
         ACC1:    nxt = RHT;
         RHT:     nxt = ACC2;
         ACC2:    nxt = LFT;
         LFT:     nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Step counter: counts within a multiply step, zero on every step entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                           cnt <= '0;
      else if ((state == ICMP || state == PCMP) && !step_end) cnt <= cnt + 2'd1;
      else                                               cnt <= '0;
   end

   // Registered controls, loaded with the upcoming state's word so they are
   // stable for the whole step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= CTRL_OFF;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         ctrl_q <= STEP_CTRL[nxt];
         busy   <= (nxt != IDLE) && (nxt != DONE);
         done   <= (nxt == DONE);
      end
   end

   assign src0sel  = ctrl_q.src0;
   assign src1sel  = ctrl_q.src1;
   assign multiply = ctrl_q.multiply;
   assign sub      = ctrl_q.sub;
   assign mult2    = ctrl_q.mult2;
   assign mult4    = ctrl_q.mult4;
   assign saturate = ctrl_q.saturate;

`ifdef ANTI_WINDUP_EN
   // Remember whether the last pass left either motor output pinned
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                sat_flag <= 1'b0;
      else if (state == LFT)                  sat_flag <= is_sat(dst[11:0]) || is_sat(rht);
   end
`endif

   // Capture dst into the current step's destination register at step end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accum  <= '0;
         pcomp  <= '0;
         icomp  <= '0;
         intgrl <= '0;
         lft    <= '0;
         rht    <= '0;
      end else if (step_end) begin
         case (state)
`ifdef ANTI_WINDUP_EN
            INTG:    if (!sat_flag) intgrl <= dst[11:0];
`else
            INTG:    intgrl <= dst[11:0];
`endif
            ICMP:    icomp  <= dst[11:0];
            PCMP:    pcomp  <= dst;
            ACC1:    accum  <= dst;
            RHT:     rht    <= dst[11:0];
            ACC2:    accum  <= dst;
            LFT:     lft    <= dst[11:0];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pid_math_seq.sv
// Randomized bench for pid_math_seq against a table-driven reference model.
// Honours ANTI_WINDUP_EN when compiled with it.
module tb_pid_math_seq;

   localparam int MC = 2;

   // Capture targets
   localparam int T_NONE = 0, T_INTG = 1, T_ICMP = 2, T_PCMP = 3,
                  T_ACC = 4, T_RHT = 5, T_LFT = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go  = 1'b0;
   logic [15:0] dst = '0;
   logic [2:0]  src0sel, src1sel;
   logic        multiply, sub, mult2, mult4, saturate;
   logic [15:0] accum, pcomp;
   logic [11:0] icomp, intgrl, lft, rht;
   logic        busy, done;

   int n_cmp = 0;
   int n_err = 0;

   pid_math_seq #(.MUL_CYC(MC)) dut (
      .clk(clk), .rst(rst), .go(go), .dst(dst),
      .src0sel(src0sel), .src1sel(src1sel), .multiply(multiply), .sub(sub),
      .mult2(mult2), .mult4(mult4), .saturate(saturate),
      .accum(accum), .pcomp(pcomp), .icomp(icomp), .intgrl(intgrl),
      .lft(lft), .rht(rht), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // One entry per busy cycle of a pass
   typedef struct {
      string nm;
      int    s0, s1, mul, sb, sat, tgt, cap;
   } cyc_t;
   cyc_t sched[$];

   // Reference register state
   logic [15:0] m_accum, m_pcomp;
   logic [11:0] m_icomp, m_intgrl, m_lft, m_rht;
   logic        m_sat;

   wire [10:0] ctrl_obs = {src0sel, src1sel, multiply, sub, mult2, mult4, saturate};
   wire [79:0] regs_obs = {accum, pcomp, icomp, intgrl, rht, lft};

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] mdl_regs();
      return {m_accum, m_pcomp, m_icomp, m_intgrl, m_rht, m_lft};
   endfunction

   function automatic logic [10:0] exp_ctrl(input int k);
      return {3'(sched[k].s0), 3'(sched[k].s1), 1'(sched[k].mul), 1'(sched[k].sb),
              2'b00, 1'(sched[k].sat)};
   endfunction

   function automatic logic pinned(input logic [11:0] v);
      return v == 12'h7FF || v == 12'h800;
   endfunction

   task automatic mdl_clear();
      m_accum = '0; m_pcomp = '0; m_icomp = '0; m_intgrl = '0;
      m_lft = '0; m_rht = '0; m_sat = 1'b0;
   endtask

   task automatic mdl_cap(input int tgt, input logic [15:0] d);
      case (tgt)
         T_INTG: if (!m_sat) m_intgrl = d[11:0];
         T_ICMP: m_icomp = d[11:0];
         T_PCMP: m_pcomp = d;
         T_ACC:  m_accum = d;
         T_RHT:  m_rht = d[11:0];
         T_LFT: begin
            m_lft = d[11:0];
`ifdef ANTI_WINDUP_EN
            m_sat = pinned(m_lft) || pinned(m_rht);
`endif
         end
         default: ;
      endcase
   endtask

   task automatic add_step(input string nm, input int s0, input int s1, input int mul,
                           input int sb, input int sat, input int tgt, input int len);
      for (int i = 0; i < len; i++)
         sched.push_back('{nm, s0, s1, mul, sb, sat, tgt, (i == len - 1) ? 1 : 0});
   endtask

   // mode 0: random dst, 1: constant val, 2: cycle index+1, 3: val except lft_val on LFT
   task automatic run_pass(input int mode, input logic [15:0] val, input logic [15:0] lft_val);
      logic [15:0] d;
      @(negedge clk); go = 1'b1; dst = 16'($urandom);
      @(negedge clk); go = 1'b0;
      for (int k = 0; k < sched.size(); k++) begin
         chk($sformatf("busy[%0d]", k), 80'(busy), 80'd1);
         chk($sformatf("done_low[%0d]", k), 80'(done), 80'd0);
         chk($sformatf("ctrl[%0d] %s", k, sched[k].nm), 80'(ctrl_obs), 80'(exp_ctrl(k)));
         chk($sformatf("regs[%0d]", k), regs_obs, mdl_regs());
         case (mode)
            0:       d = 16'($urandom);
            1:       d = val;
            2:       d = 16'(k + 1);
            default: d = (sched[k].tgt == T_LFT) ? lft_val : val;
         endcase
         dst = d;
         if (sched[k].cap != 0) mdl_cap(sched[k].tgt, d);
         @(negedge clk);
      end
      chk("done_pulse", 80'(done), 80'd1);
      chk("busy_in_done", 80'(busy), 80'd0);
      chk("ctrl_in_done", 80'(ctrl_obs), 80'd0);
      chk("regs_end", regs_obs, mdl_regs());
      @(negedge clk);
      chk("done_width", 80'(done), 80'd0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      #1;
      chk("rst_ctrl", 80'(ctrl_obs), 80'd0);
      chk("rst_flags", 80'({busy, done}), 80'd0);
      chk("rst_regs", regs_obs, 80'd0);
      mdl_clear();
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      int dcnt;
      int starts[$];
      int dones[$];
      mdl_clear();
      add_step("INTG", 1, 3, 0, 0, 1, T_INTG, 1);
      add_step("ICMP", 1, 1, 1, 0, 0, T_ICMP, MC);
      add_step("PCMP", 4, 2, 1, 0, 0, T_PCMP, MC);
      add_step("ACC1", 3, 4, 0, 1, 0, T_ACC,  1);
      add_step("RHT",  2, 0, 0, 1, 1, T_RHT,  1);
      add_step("ACC2", 3, 4, 0, 0, 0, T_ACC,  1);
      add_step("LFT",  2, 0, 0, 0, 1, T_LFT,  1);

      // Reset state
      repeat (2) @(negedge clk);
      chk("init_ctrl", 80'(ctrl_obs), 80'd0);
      chk("init_flags", 80'({busy, done}), 80'd0);
      chk("init_regs", regs_obs, 80'd0);
      rst = 1'b0;

      // Fixed-value pass, then step-index pass
      run_pass(1, 16'h1234, 16'h0);
      chk("const_intgrl", 80'(intgrl), 80'h234);
      chk("const_pcomp", 80'(pcomp), 80'h1234);
      run_pass(2, 16'h0, 16'h0);
      chk("idx_regs", regs_obs, {16'd8, 16'd5, 12'd3, 12'd1, 12'd7, 12'd9});

      // Reset mid-pass: two cycles after go
      @(negedge clk); go = 1'b1; dst = 16'hBEEF;
      @(negedge clk); go = 1'b0;
      @(negedge clk);
      do_reset();
      dcnt = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("no_done_after_rst", 80'(dcnt), 80'd0);
      chk("idle_after_rst", 80'({busy, ctrl_obs}), 80'd0);

      // Random passes; Intgrl/Accum persist between them
      for (int p = 0; p < 4; p++) run_pass(0, 16'h0, 16'h0);

      // go held high for 30 cycles: a new pass every 9 busy + DONE + IDLE cycles
      for (int s = 1; s <= 30; s += sched.size() + 2) begin
         starts.push_back(s);
         dones.push_back(s + sched.size());
      end
      dcnt = 0;
      @(negedge clk); go = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         dst = 16'($urandom);
         @(negedge clk);
         if (c == 30) go = 1'b0;
         if (done) dcnt++;
         chk($sformatf("cont_done[%0d]", c), 80'(done), 80'((c inside {dones}) ? 1 : 0));
      end
      chk("cont_done_count", 80'(dcnt), 80'(dones.size()));
      go = 1'b0;

      // Saturated LFT in pass 1, then two ordinary passes
      do_reset();
      run_pass(3, 16'h0055, 16'h07FF);
      run_pass(1, 16'h0066, 16'h0);
`ifdef ANTI_WINDUP_EN
      chk("windup_intgrl", 80'(intgrl), 80'h055);
`else
      chk("windup_intgrl", 80'(intgrl), 80'h066);
`endif
      run_pass(1, 16'h0077, 16'h0);
      chk("windup_release", 80'(intgrl), 80'h077);
      run_pass(3, 16'h0123, 16'h0800);
      run_pass(0, 16'h0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
